// File: rtl/wb_mux_n_pkg.sv
// rtl/wb_mux_n_pkg.sv - shared state encoding and default response data for wb_mux_n
// Optional error response is enabled by defining WB_MUX_N_ERR_EN.
package wb_mux_n_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_WAIT = S_WAIT,
    ST_RESP = S_RESP
  } state_e;

  localparam logic [31:0] TIMEOUT_RDT  = 32'hDEADBEEF;
  localparam logic [31:0] UNMAPPED_RDT = 32'h0;

endpackage

// File: rtl/wb_mux_n_dec.sv
// rtl/wb_mux_n_dec.sv - slave index to one-hot select decode with mapped flag
// Purely combinational; an index with no matching slave yields onehot == 0.
module wb_mux_n_dec
  import wb_mux_n_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int IDX_W      = 2
) (
  input  logic [IDX_W-1:0]      idx,
  output logic [NUM_SLAVES-1:0] onehot,
  output logic                  mapped
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (32'(idx) == 32'(i)) begin
        onehot[i] = 1'b1;
      end
    end
    mapped = |onehot;
  end

endmodule

// File: rtl/wb_mux_n.sv
// rtl/wb_mux_n.sv - SERV-style Wishbone master to NUM_SLAVES slave splitter with watchdog
// Define WB_MUX_N_ERR_EN to add o_wb_cpu_err for timeout and unmapped accesses.
module wb_mux_n
  import wb_mux_n_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int SEL_MSB    = 31,
  parameter int SEL_LSB    = 30,
  parameter int TIMEOUT    = 15
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [31:0]              i_wb_cpu_adr,
  input  logic [31:0]              i_wb_cpu_dat,
  input  logic [3:0]               i_wb_cpu_sel,
  input  logic                     i_wb_cpu_we,
  input  logic                     i_wb_cpu_cyc,
  output logic [31:0]              o_wb_cpu_rdt,
  output logic                     o_wb_cpu_ack,
`ifdef WB_MUX_N_ERR_EN
  output logic                     o_wb_cpu_err,
`endif
  output logic [31:0]              o_wb_s_adr,
  output logic [31:0]              o_wb_s_dat,
  output logic [3:0]               o_wb_s_sel,
  output logic                     o_wb_s_we,
  output logic [NUM_SLAVES-1:0]    o_wb_s_cyc,
  input  logic [32*NUM_SLAVES-1:0] i_wb_s_rdt,
  input  logic [NUM_SLAVES-1:0]    i_wb_s_ack
);

  localparam int IDX_W = SEL_MSB - SEL_LSB + 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

  state_e                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [31:0]             rdt_q, rdt_d;
  logic                    ack_q, ack_d;
`ifdef WB_MUX_N_ERR_EN
  logic                    err_q, err_d;
`endif

  logic [IDX_W-1:0]        idx;
  logic [NUM_SLAVES-1:0]   dec_onehot;
  logic                    dec_mapped;
  logic [31:0]             slv_rdt;
  logic                    slv_ack;

  assign idx = i_wb_cpu_adr[SEL_MSB:SEL_LSB];

  wb_mux_n_dec #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W)
  ) u_dec (
    .idx    (idx),
    .onehot (dec_onehot),
    .mapped (dec_mapped)
  );

  assign o_wb_s_adr = i_wb_cpu_adr;
  assign o_wb_s_dat = i_wb_cpu_dat;
  assign o_wb_s_sel = i_wb_cpu_sel;
  assign o_wb_s_we  = i_wb_cpu_we;

  // sel_q is the registered index kept in one-hot form, so it gates cyc, ack and rdt directly.
  assign o_wb_s_cyc = sel_q & {NUM_SLAVES{(state_q == ST_WAIT) && i_wb_cpu_cyc}};

  assign o_wb_cpu_rdt = rdt_q;
  assign o_wb_cpu_ack = ack_q;
`ifdef WB_MUX_N_ERR_EN
  assign o_wb_cpu_err = err_q;
`endif

  always_comb begin
    slv_rdt = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        slv_rdt = slv_rdt | i_wb_s_rdt[32*i +: 32];
      end
    end
    slv_ack = |(i_wb_s_ack & sel_q);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    timer_d = timer_q;
    rdt_d   = rdt_q;
    ack_d   = 1'b0;
`ifdef WB_MUX_N_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_wb_cpu_cyc) begin
          sel_d   = dec_onehot;
          timer_d = '0;
          if (dec_mapped) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RESP;
            rdt_d   = UNMAPPED_RDT;
`ifdef WB_MUX_N_ERR_EN
            err_d   = 1'b1;
`else
            ack_d   = 1'b1;
`endif
          end
        end
      end
      ST_WAIT: begin
        // A real slave ack beats a watchdog expiry landing on the same cycle.
        if (!i_wb_cpu_cyc) begin
          state_d = ST_IDLE;
        end else if (slv_ack) begin
          state_d = ST_RESP;
          rdt_d   = slv_rdt;
          ack_d   = 1'b1;
        end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
          state_d = ST_RESP;
`ifdef WB_MUX_N_ERR_EN
          rdt_d   = '0;
          err_d   = 1'b1;
`else
          rdt_d   = TIMEOUT_RDT;
          ack_d   = 1'b1;
`endif
        end else if (timer_q != TMR_MAX) begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      timer_q <= '0;
      rdt_q   <= '0;
      ack_q   <= 1'b0;
`ifdef WB_MUX_N_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
      rdt_q   <= rdt_d;
      ack_q   <= ack_d;
`ifdef WB_MUX_N_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: doc/wb_mux_n.md
Name: wb_mux_n

Overview:
- Parametrised successor to the two-way CPU Wishbone splitter.
- Routes one SERV-style Wishbone master (classic, cyc-only, no stb) to NUM_SLAVES slaves, selected by a configurable address bit-field.
- Unlike the fixed-latency splitter, it waits for the real slave ack, registers read data and enforces a watchdog timeout.
- Unmapped addresses get a default response, so the CPU never hangs.

Parameters:
- NUM_SLAVES, 2, number of slave ports (1..16).
- SEL_MSB, 31, top address bit of the slave-select field.
- SEL_LSB, 30, bottom address bit of the slave-select field.
- TIMEOUT, 15, cycles to wait in WAIT before forcing a response; 0 disables the watchdog.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_wb_cpu_adr  in  32  master address.
- i_wb_cpu_dat  in  32  master write data.
- i_wb_cpu_sel  in  4  byte selects.
- i_wb_cpu_we  in  1  write enable.
- i_wb_cpu_cyc  in  1  master cycle request.
- o_wb_cpu_rdt  out  32  registered read data.
- o_wb_cpu_ack  out  1  registered single-cycle ack.
- o_wb_s_adr  out  32  shared address, passed through.
- o_wb_s_dat  out  32  shared write data, passed through.
- o_wb_s_sel  out  4  shared byte selects.
- o_wb_s_we  out  1  shared write enable.
- o_wb_s_cyc  out  NUM_SLAVES  one-hot per-slave cycle.
- i_wb_s_rdt  in  32*NUM_SLAVES  slave read data, slave i at bits [32i+31:32i].
- i_wb_s_ack  in  NUM_SLAVES  per-slave ack.

Behaviour:
- Reset (i_rst_n low, async): state=IDLE, idx=0, timer=0, o_wb_cpu_ack=0, o_wb_cpu_rdt=0; o_wb_s_cyc=0.
- idx = i_wb_cpu_adr[SEL_MSB:SEL_LSB]. The index is mapped if idx < NUM_SLAVES.
- adr/dat/sel/we pass combinationally to the shared slave bus. The master holds them stable for the whole cycle.
- o_wb_s_cyc[i] = (state==WAIT) & (idx_q==i) & i_wb_cpu_cyc, where idx_q is registered.
- FSM, three states:
  - IDLE: if i_wb_cpu_cyc, latch idx_q and clear the timer.
    - Mapped index: go to WAIT.
    - Unmapped index: go to RESP with rdt_q=32'h0.
  - WAIT: selected slave cyc is high.
    - If i_wb_s_ack[idx_q]: rdt_q=i_wb_s_rdt[idx_q], go to RESP.
    - Else if TIMEOUT!=0 and timer==TIMEOUT-1: rdt_q=32'hDEADBEEF, go to RESP.
    - Else timer++.
    - If i_wb_cpu_cyc drops while in WAIT (abort): go to IDLE, no ack.
  - RESP: o_wb_cpu_ack=1 for exactly one cycle, then IDLE. The master drops cyc in the cycle after ack. IDLE never re-triggers from a stale cyc because RESP→IDLE consumes that cycle.
- Latency, cyc rise to ack: 2 cycles with a combinational slave ack; 2+N with a slave ack delayed N cycles; TIMEOUT+1 on timeout; 1 when unmapped.
- Slave ack arriving on the same cycle the timer expires: the slave wins and real data is returned.
- Acks from non-selected slaves, or any ack outside WAIT, are ignored.
- Timer width is clog2(TIMEOUT+1). It saturates and never wraps.
- Reset asserted mid-transaction returns to IDLE immediately; no ack is issued.

Optional Feature:
- Macro: WB_MUX_N_ERR_EN.
- Defined:
  - Adds output o_wb_cpu_err (1 bit, reset 0).
  - On timeout or unmapped access, err pulses instead of ack, in the same cycle ack would have pulsed; rdt_q=0.
- Undefined:
  - No err port; timeout and unmapped accesses complete with ack and the default data above.

Decomposition:
- Package wb_mux_n_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2;
  - constants TIMEOUT_RDT=32'hDEADBEEF and UNMAPPED_RDT=32'h0.
- One natural sub-module, wb_mux_n_dec: combinational decode of idx → one-hot select plus a mapped flag, reused by future interconnects.
- The FSM, timer and data capture stay in the top.

Test Plan:
- Read, NUM_SLAVES=2, adr=0x4000_0000, slave1 acks combinationally with rdt=0x0000_0001 → o_wb_s_cyc=2'b10 for 1 cycle, ack at cycle 2, o_wb_cpu_rdt=0x1.
- Write, adr=0x0000_0010, dat=0xA5A5_5A5A, sel=4'hF, slave0 acks after 3 cycles → slave sees stable adr/dat/we=1 for 4 cycles; single ack at cycle 5.
- NUM_SLAVES=3, adr=0xC000_0000 (idx 3) → no slave cyc; ack after 1 cycle, rdt=0 (err=1 with WB_MUX_N_ERR_EN).
- TIMEOUT=15, slave never acks → slave cyc high 15 cycles, then ack with rdt=0xDEADBEEF (err instead, with the macro). Repeat with ack landing on the expiry cycle → real data returned.
- Drop cyc in WAIT at cycle 3, then i_rst_n low mid-WAIT in a second run → no ack; all outputs 0; the next transaction completes normally.
- Back-to-back transactions slave0→slave1 with cyc re-asserted the cycle after ack drops → exactly one ack each; no double ack.
